// File: rtl/aes_pkg.sv
// Shared types, constants and helpers for the AES-128 key schedule.
package aes_pkg;

   typedef logic [7:0]   byte_t;
   typedef logic [31:0]  word_t;
   typedef logic [127:0] block_t;

   typedef enum logic [1:0] {IDLE, EMIT, DONE} kexp_state_t;

   // Round constants for rounds 1..10 (high byte of the XOR word).
   localparam byte_t RCON [1:10] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   // Forward AES S-box, row = high nibble, column = low nibble.
   localparam byte_t SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
      8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
      8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
      8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
      8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
      8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
      8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
      8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
      8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
      8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
      8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
      8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
      8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
      8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
      8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
      8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
      8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Cyclic left byte rotation: [a0,a1,a2,a3] -> [a1,a2,a3,a0], a0 in the MSB.
   function automatic word_t rot_word(input word_t w);
      return {w[23:0], w[31:24]};
   endfunction

endpackage

// File: rtl/sbox_unit.sv
// Single-byte forward AES S-box lookup, purely combinational.
module sbox_unit
   import aes_pkg::*;
(
   input  logic [7:0] din,
   output logic [7:0] dout
);

   assign dout = SBOX[din];

endmodule

// File: rtl/sub_word.sv
// SubWord: four parallel S-box lookups across the bytes of a word.
module sub_word
   import aes_pkg::*;
(
   input  logic [31:0] word_in,
   output logic [31:0] word_out
);

   for (genvar i = 0; i < 4; i++) begin : g_lane
      sbox_unit u_sbox (
         .din  (word_in[8*i +: 8]),
         .dout (word_out[8*i +: 8])
      );
   end

endmodule

// File: rtl/aes_key_expander.sv
// Sequential AES-128 key schedule: one round key per accepted valid/ready beat.
// Optional build macro AES_KEY_STORE_EN adds an 11-entry round-key store with a
// combinational read port (rd_addr/rd_data).
module aes_key_expander
   import aes_pkg::*;
#(
   parameter int unsigned NUM_ROUNDS = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key_in,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] rk_data,
   output logic [3:0]   rk_index,
   output logic         busy,
   output logic         done
`ifdef AES_KEY_STORE_EN
   ,
   input  logic [3:0]   rd_addr,
   output logic [127:0] rd_data
`endif
);

   localparam logic [3:0] LastRound = 4'(NUM_ROUNDS);

   kexp_state_t state_q, state_d;
   block_t      w_q, w_d;
   logic [3:0]  round_q, round_d;

   word_t  sub_out;
   word_t  tmp;
   byte_t  rcon_sel;
   word_t  nw0, nw1, nw2, nw3;
   logic   handshake;

   sub_word u_sub_word (
      .word_in  (rot_word(w_q[31:0])),
      .word_out (sub_out)
   );

   // Next-round key XOR network, computed from the registered key words.
   always_comb begin
      rcon_sel = '0;
      if (round_q < LastRound) rcon_sel = RCON[round_q + 4'd1];
      tmp = sub_out ^ {rcon_sel, 24'h0};
      nw0 = w_q[127:96] ^ tmp;
      nw1 = w_q[95:64]  ^ nw0;
      nw2 = w_q[63:32]  ^ nw1;
      nw3 = w_q[31:0]   ^ nw2;
   end

   assign handshake = rk_valid & rk_ready;

   // FSM next-state, key and round counter updates.
   always_comb begin
      state_d = state_q;
      w_d     = w_q;
      round_d = round_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               w_d     = key_in;
               round_d = '0;
               state_d = EMIT;
            end
         end
         EMIT: begin
            if (handshake) begin
               if (round_q < LastRound) begin
                  w_d     = {nw0, nw1, nw2, nw3};
                  round_d = round_q + 4'd1;
               end else begin
                  state_d = DONE;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State, key and round registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         w_q     <= '0;
         round_q <= '0;
      end else begin
         state_q <= state_d;
         w_q     <= w_d;
         round_q <= round_d;
      end
   end

   assign rk_valid = (state_q == EMIT);
   assign rk_data  = w_q;
   assign rk_index = round_q;
   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);

`ifdef AES_KEY_STORE_EN
   block_t store_q [NUM_ROUNDS+1];

   // Round-key store, written on every accepted beat, cleared on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i <= int'(NUM_ROUNDS); i++) store_q[i] <= '0;
      end else if (handshake) begin
         store_q[round_q] <= w_q;
      end
   end

   // Combinational read; out-of-range addresses read as zero.
   always_comb begin
      rd_data = '0;
      if (rd_addr <= LastRound) rd_data = store_q[rd_addr];
   end
`endif

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander: S-box sweep, directed key vectors,
// backpressure, ignored starts, mid-run reset and (optionally) the key store.
module tb_aes_key_expander;
   import aes_pkg::*;

   logic         clk = 1'b0;
   logic         rst, start, rk_ready;
   logic [127:0] key_in;
   logic         rk_valid, busy, done;
   logic [127:0] rk_data;
   logic [3:0]   rk_index;
   logic [31:0]  sw_in, sw_out;
`ifdef AES_KEY_STORE_EN
   logic [3:0]   rd_addr;
   logic [127:0] rd_data;
`endif

   int checks = 0;
   int errors = 0;

   byte_t gold_sbox [256];
   byte_t gold_rcon [1:10];

   always #5 clk = ~clk;

   aes_key_expander #(.NUM_ROUNDS(10)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .key_in   (key_in),
      .rk_valid (rk_valid),
      .rk_ready (rk_ready),
      .rk_data  (rk_data),
      .rk_index (rk_index),
      .busy     (busy),
      .done     (done)
`ifdef AES_KEY_STORE_EN
      ,
      .rd_addr  (rd_addr),
      .rd_data  (rd_data)
`endif
   );

   sub_word u_sw (
      .word_in  (sw_in),
      .word_out (sw_out)
   );

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic byte_t gmul(input byte_t a, input byte_t b);
      byte_t p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic byte_t rotl8(input byte_t v, input int k);
      return byte_t'((v << k) | (v >> (8 - k)));
   endfunction

   // S-box from first principles: GF(2^8) inverse followed by the affine map.
   task automatic build_gold();
      byte_t inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(byte_t'(x), byte_t'(y)) == 8'h01) inv = byte_t'(y);
         gold_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4)
                        ^ 8'h63;
      end
      gold_rcon[1] = 8'h01;
      for (int r = 2; r <= 10; r++) gold_rcon[r] = gmul(gold_rcon[r-1], 8'h02);
   endtask

   task automatic model_keys(input block_t key, output block_t ks [11]);
      word_t w0, w1, w2, w3, t;
      {w0, w1, w2, w3} = key;
      ks[0] = key;
      for (int r = 1; r <= 10; r++) begin
         t  = {gold_sbox[w3[23:16]], gold_sbox[w3[15:8]], gold_sbox[w3[7:0]],
               gold_sbox[w3[31:24]]} ^ {gold_rcon[r], 24'h0};
         w0 = w0 ^ t;
         w1 = w1 ^ w0;
         w2 = w2 ^ w1;
         w3 = w3 ^ w2;
         ks[r] = {w0, w1, w2, w3};
      end
   endtask

   // Run one expansion. stall_pct>0 adds random backpressure and start pulses while busy.
   task automatic expand(input block_t key, input int stall_pct, output block_t got [11]);
      int     n = 0;
      bit     stalled = 1'b0;
      bit     fin = 1'b0;
      block_t pd = '0;
      for (int i = 0; i < 11; i++) got[i] = '0;
      @(negedge clk);
      start    = 1'b1;
      key_in   = key;
      rk_ready = 1'($urandom_range(1));
      for (int c = 1; c <= 400 && !fin; c++) begin
         @(negedge clk);
         start  = 1'b0;
         key_in = {$urandom, $urandom, $urandom, $urandom};
         if (n == 11) begin
            chk("done_pulse", {rk_valid, done}, 2'b01);
            if (stall_pct == 0) chk("done_latency", c, 12);
            if (stall_pct > 0) start = 1'b1;
            fin = 1'b1;
         end else begin
            chk("valid_until_hs", {rk_valid, busy, done}, 3'b110);
            chk("rk_index", rk_index, n);
            if (stalled) chk("stall_stable", rk_data, pd);
            rk_ready = ($urandom_range(99) >= stall_pct);
            if (stall_pct > 0 && $urandom_range(3) == 0) start = 1'b1;
            if (rk_valid && rk_ready) begin
               got[n] = rk_data;
               n++;
            end
            stalled = rk_valid && !rk_ready;
            pd      = rk_data;
         end
      end
      if (!fin) chk("expand_timeout", 1'b0, 1'b1);
      @(negedge clk);
      start    = 1'b0;
      rk_ready = 1'b0;
      chk("idle_after_done", {rk_valid, busy, done}, 3'b000);
   endtask

   typedef struct {
      string  name;
      block_t key;
      int     idx;
      block_t exp;
   } vec_t;

   localparam block_t FipsKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   vec_t   vecs [6];
   block_t got [11];
   block_t mdl [11];

   initial begin
      vecs[0] = '{"fips_idx0",  FipsKey, 0,  FipsKey};
      vecs[1] = '{"fips_idx1",  FipsKey, 1,  128'ha0fafe1788542cb123a339392a6c7605};
      vecs[2] = '{"fips_idx2",  FipsKey, 2,  128'hf2c295f27a96b9435935807a7359f67f};
      vecs[3] = '{"zero_idx1",  '0,      1,  128'h62636363626363636263636362636363};
      vecs[4] = '{"zero_idx10", '0,      10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
      vecs[5] = '{"fips_idx10", FipsKey, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

      rst = 1'b1; start = 1'b0; rk_ready = 1'b0; key_in = '0; sw_in = '0;
`ifdef AES_KEY_STORE_EN
      rd_addr = '0;
`endif
      build_gold();
      repeat (2) @(negedge clk);
      chk("reset_flags", {rk_valid, busy, done}, 3'b000);
      chk("reset_data", rk_data, '0);
      chk("reset_index", rk_index, '0);
      // Ready while idle must have no effect.
      rk_ready = 1'b1;
      rst = 1'b0;
      @(negedge clk);
      chk("idle_ready_noeffect", {rk_valid, busy, done}, 3'b000);
      rk_ready = 1'b0;

      for (int i = 0; i < 256; i++) begin
         byte_t b0, b1, b2, b3;
         b0 = byte_t'(i); b1 = byte_t'(i + 85); b2 = byte_t'(i + 170); b3 = byte_t'(255 - i);
         sw_in = {b0, b1, b2, b3};
         #1;
         chk($sformatf("sub_word_%0d", i), sw_out,
             {gold_sbox[b0], gold_sbox[b1], gold_sbox[b2], gold_sbox[b3]});
      end
      sw_in = 32'hbcbdbcbd;
      #1;
      chk("sub_word_bc_bd", sw_out, 32'h657a657a);

      for (int v = 0; v < 6; v++) begin
         expand(vecs[v].key, 0, got);
         chk(vecs[v].name, got[vecs[v].idx], vecs[v].exp);
         model_keys(vecs[v].key, mdl);
         for (int k = 0; k < 11; k++) chk($sformatf("%s_model_k%0d", vecs[v].name, k),
                                          got[k], mdl[k]);
      end

`ifdef AES_KEY_STORE_EN
      rd_addr = 4'd10; #1; chk("store_idx10", rd_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      rd_addr = 4'd0;  #1; chk("store_idx0", rd_data, FipsKey);
      rd_addr = 4'd15; #1; chk("store_idx15", rd_data, '0);
`endif

      model_keys(FipsKey, mdl);
      expand(FipsKey, 40, got);
      for (int k = 0; k < 11; k++) chk($sformatf("bp_fips_k%0d", k), got[k], mdl[k]);
      begin
         block_t rk;
         rk = {$urandom, $urandom, $urandom, $urandom};
         model_keys(rk, mdl);
         expand(rk, 30, got);
         for (int k = 0; k < 11; k++) chk($sformatf("bp_rand_k%0d", k), got[k], mdl[k]);
      end

      // Reset while stalled on round key 5.
      model_keys(FipsKey, mdl);
      @(negedge clk); start = 1'b1; key_in = FipsKey; rk_ready = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (5) @(negedge clk);
      rk_ready = 1'b0;
      chk("rst_pre_idx", rk_index, 4'd5);
      @(negedge clk);
      chk("rst_pre_hold", rk_data, mdl[5]);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid_flags", {rk_valid, busy, done}, 3'b000);
      chk("rst_mid_data", {rk_data, rk_index}, '0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_no_done", {rk_valid, busy, done}, 3'b000);
      end
      expand(FipsKey, 20, got);
      for (int k = 0; k < 11; k++) chk($sformatf("post_rst_k%0d", k), got[k], mdl[k]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
